// File: rtl/utopia1_phy_tx_if.sv
// Utopia level 1 transmit bundle: ATM-layer cell input, egress byte stream and error pulses.
// master = ATM layer / line-side consumer, slave = PHY cell buffer.
interface utopia1_phy_tx_if;
  logic [7:0] atm_data;
  logic       atm_soc;
  logic       atm_en;
  logic       atm_clav;
  logic [7:0] out_data;
  logic       out_soc;
  logic       out_valid;
  logic       out_ready;
  logic       err_runt;
  logic       err_ovfl;
  logic       err_hec;

  modport master (
    output atm_data, atm_soc, atm_en, out_ready,
    input  atm_clav, out_data, out_soc, out_valid, err_runt, err_ovfl, err_hec
  );

  modport slave (
    input  atm_data, atm_soc, atm_en, out_ready,
    output atm_clav, out_data, out_soc, out_valid, err_runt, err_ovfl, err_hec
  );
endinterface

// File: rtl/utopia1_phy_tx.sv
// Utopia-1 PHY transmit side: buffers whole 53-byte cells and replays them on a ready/valid port.
// Define HEC_CHECK_EN to drop cells whose header byte 4 fails the CRC-8 HEC test.
module utopia1_phy_tx #(
  parameter int NUM_CELLS = 4
) (
  input logic             clk,
  input logic             reset,
  utopia1_phy_tx_if.slave bus
);
  localparam int CELL_BYTES = 53;
  localparam int SLOT_W     = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int ADDR_W     = $clog2(NUM_CELLS * CELL_BYTES);
  localparam int CNT_W      = $clog2(NUM_CELLS + 1);
  localparam logic [5:0] LAST_BYTE = 6'd52;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [5:0]          wr_byte_q, wr_byte_d, rd_byte_q, rd_byte_d;
  logic [5:0]          drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]    count_q, count_d, occ_d;
  logic                clav_q, clav_d;
  logic                runt_q, runt_d, ovfl_q, ovfl_d;
  logic                mem_we, commit, accept, out_valid, xfer, pop;
  logic [5:0]          wr_idx;
  logic [ADDR_W-1:0]   waddr, raddr;
  logic [7:0]          mem [NUM_CELLS*CELL_BYTES];
`ifdef HEC_CHECK_EN
  logic [7:0]          crc_q, crc_d;
  logic                hec_bad_q, hec_bad_d, hec_q, hec_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction
`endif

  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    return (s == SLOT_W'(NUM_CELLS - 1)) ? '0 : s + SLOT_W'(1);
  endfunction

  assign accept    = !bus.atm_en;
  assign out_valid = (count_q != '0);
  assign xfer      = out_valid && bus.out_ready;
  assign pop       = xfer && (rd_byte_q == LAST_BYTE);
  assign waddr     = ADDR_W'(wr_slot_q) * ADDR_W'(CELL_BYTES) + ADDR_W'(wr_idx);
  assign raddr     = ADDR_W'(rd_slot_q) * ADDR_W'(CELL_BYTES) + ADDR_W'(rd_byte_q);

  always_comb begin
    state_d    = state_q;
    wr_slot_d  = wr_slot_q;
    rd_slot_d  = rd_slot_q;
    wr_byte_d  = wr_byte_q;
    rd_byte_d  = rd_byte_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    runt_d     = 1'b0;
    ovfl_d     = 1'b0;
    mem_we     = 1'b0;
    commit     = 1'b0;
    wr_idx     = wr_byte_q;
`ifdef HEC_CHECK_EN
    crc_d      = crc_q;
    hec_bad_d  = hec_bad_q;
    hec_d      = 1'b0;
`endif
    if (xfer) begin
      rd_byte_d = pop ? 6'd0 : rd_byte_q + 6'd1;
      if (pop) rd_slot_d = next_slot(rd_slot_q);
    end

    case (state_q)
      S_IDLE: if (accept && bus.atm_soc) begin
        if (count_q < CNT_W'(NUM_CELLS)) begin
          mem_we    = 1'b1;
          wr_idx    = 6'd0;
          wr_byte_d = 6'd1;
          state_d   = S_RECV;
        end else begin
          ovfl_d     = 1'b1;
          drop_cnt_d = 6'd1;
          state_d    = S_DROP;
        end
      end
      S_RECV: if (accept) begin
        mem_we = 1'b1;
        if (bus.atm_soc) begin
          // early soc: restart the cell in place, the partial bytes are simply overwritten
          runt_d    = 1'b1;
          wr_idx    = 6'd0;
          wr_byte_d = 6'd1;
        end else if (wr_byte_q == LAST_BYTE) begin
          commit    = 1'b1;
          wr_byte_d = 6'd0;
          state_d   = S_IDLE;
        end else begin
          wr_byte_d = wr_byte_q + 6'd1;
        end
      end
      S_DROP: if (accept) begin
        if (bus.atm_soc)                    drop_cnt_d = 6'd1;
        else if (drop_cnt_q == LAST_BYTE)   state_d    = S_IDLE;
        else                                drop_cnt_d = drop_cnt_q + 6'd1;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef HEC_CHECK_EN
    if (mem_we) begin
      if (wr_idx < 6'd4)  crc_d     = crc8_step((wr_idx == 6'd0) ? 8'h00 : crc_q, bus.atm_data);
      if (wr_idx == 6'd0) hec_bad_d = 1'b0;
      if (wr_idx == 6'd4) hec_bad_d = (bus.atm_data != (crc_q ^ 8'h55));
    end
    if (commit && hec_bad_q) begin
      commit = 1'b0;
      hec_d  = 1'b1;
    end
`endif
    if (commit) wr_slot_d = next_slot(wr_slot_q);

    case ({commit, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    occ_d  = count_d + CNT_W'(state_d == S_RECV);
    clav_d = (occ_d < CNT_W'(NUM_CELLS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_slot_q  <= '0;
      rd_slot_q  <= '0;
      wr_byte_q  <= '0;
      rd_byte_q  <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      clav_q     <= 1'b0;
      runt_q     <= 1'b0;
      ovfl_q     <= 1'b0;
`ifdef HEC_CHECK_EN
      crc_q      <= '0;
      hec_bad_q  <= 1'b0;
      hec_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      wr_byte_q  <= wr_byte_d;
      rd_byte_q  <= rd_byte_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      clav_q     <= clav_d;
      runt_q     <= runt_d;
      ovfl_q     <= ovfl_d;
`ifdef HEC_CHECK_EN
      crc_q      <= crc_d;
      hec_bad_q  <= hec_bad_d;
      hec_q      <= hec_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= bus.atm_data;
  end

  assign bus.atm_clav  = clav_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem[raddr] : 8'h00;
  assign bus.out_soc   = out_valid && (rd_byte_q == 6'd0);
  assign bus.err_runt  = runt_q;
  assign bus.err_ovfl  = ovfl_q;
`ifdef HEC_CHECK_EN
  assign bus.err_hec   = hec_q;
`else
  assign bus.err_hec   = 1'b0;
`endif
endmodule
